// File: rtl/adder44_rr_arbiter.sv
// Two-requester round-robin front end that shares one 44-bit + 13-bit adder.
// Results are registered in a single output slot with valid/ready handshaking.

module adder44_zext (
  input  logic [43:0] a,
  input  logic [12:0] b,
  output logic [44:0] sum
);
  assign sum = {1'b0, a} + {32'b0, b};
endmodule

module adder44_rr_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [43:0] req0_a,
  input  logic [12:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [43:0] req1_a,
  input  logic [12:0] req1_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [44:0] res_sum,
  output logic        res_id
);

  logic        last_grant;
  logic        slot_free;
  logic        grant;
  logic        xfer;
  logic [43:0] op_a;
  logic [12:0] op_b;
  logic [44:0] sum;

  // Readies are built only from the valids, the slot state and last_grant,
  // so neither port's ready can loop through the other's.
  always_comb begin
    slot_free = !res_valid || res_ready;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = req1_valid;
    end
    req0_ready = rst_n && slot_free && req0_valid && !grant;
    req1_ready = rst_n && slot_free && req1_valid &&  grant;
    xfer       = req0_ready || req1_ready;
    op_a       = grant ? req1_a : req0_a;
    op_b       = grant ? req1_b : req0_b;
  end

  adder44_zext u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      res_valid  <= 1'b1;
      res_sum    <= sum;
      res_id     <= grant;
      last_grant <= grant;
    end else if (res_ready) begin
      res_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder44_rr_arbiter.sv
// Directed bench for adder44_rr_arbiter: a per-cycle reference model checked
// on every falling edge, plus literal expectations at the key points.

module tb_adder44_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
  logic [43:0] req0_a = '0, req1_a = '0;
  logic [12:0] req0_b = '0, req1_b = '0;
  logic        req0_ready, req1_ready, res_valid, res_id;
  logic [44:0] res_sum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder44_rr_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_id     (res_id)
  );

  task automatic chk(input string name, input logic [44:0] act, input logic [44:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one result slot, plus the identity of whoever was
  // served last.
  logic        m_valid, m_id, m_last;
  logic [44:0] m_sum;

  function automatic logic [1:0] model_ready();
    logic free, who;
    free = !m_valid || res_ready;
    if (!rst_n || !free) return 2'b00;
    if (req0_valid && req1_valid) who = !m_last;
    else if (req1_valid) who = 1'b1;
    else if (req0_valid) who = 1'b0;
    else return 2'b00;
    return who ? 2'b10 : 2'b01;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_sum   <= '0;
      m_id    <= 1'b0;
      m_last  <= 1'b1;
    end else begin
      logic [1:0] r;
      r = model_ready();
      if (r[0]) begin
        m_valid <= 1'b1; m_id <= 1'b0; m_last <= 1'b0;
        m_sum   <= 45'(req0_a) + 45'(req0_b);
      end else if (r[1]) begin
        m_valid <= 1'b1; m_id <= 1'b1; m_last <= 1'b1;
        m_sum   <= 45'(req1_a) + 45'(req1_b);
      end else if (res_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] r;
    r = model_ready();
    chk("cyc_req0_ready", 45'(req0_ready), 45'(r[0]));
    chk("cyc_req1_ready", 45'(req1_ready), 45'(r[1]));
    chk("cyc_res_valid",  45'(res_valid),  45'(m_valid));
    chk("cyc_res_sum",    res_sum,         m_sum);
    chk("cyc_res_id",     45'(res_id),     45'(m_id));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [43:0] a0, input logic [12:0] b0,
                       input logic v1, input logic [43:0] a1, input logic [12:0] b1,
                       input logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    res_ready  = rr;
  endtask

  initial begin
    logic [44:0] held;
    // Reset state
    #12;
    chk("rst_res_valid", 45'(res_valid), 45'd0);
    chk("rst_res_sum", res_sum, 45'd0);
    drive(1, 44'd1, 13'd1, 1, 44'd2, 13'd2, 1);
    #1;
    chk("rst_ready0_low", 45'(req0_ready), 45'd0);
    chk("rst_ready1_low", 45'(req1_ready), 45'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;

    // First transfer, single-cycle latency
    drive(1, 44'h000_0000_0005, 13'h003, 0, 0, 0, 1);
    #1;
    chk("first_req0_ready", 45'(req0_ready), 45'd1);
    tick();
    chk("first_res_valid", 45'(res_valid), 45'd1);
    chk("first_res_sum", res_sum, 45'h8);
    chk("first_res_id", 45'(res_id), 45'd0);

    // Max operands via requester 1
    drive(0, 0, 0, 1, 44'hFFF_FFFF_FFFF, 13'h1FFF, 1);
    tick();
    chk("max_res_sum", res_sum, 45'h1000_0000_1FFE);
    chk("max_res_id", 45'(res_id), 45'd1);

    // Drain with nothing pending: valid drops, data held
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("drain_valid", 45'(res_valid), 45'd0);
    chk("drain_sum_held", res_sum, 45'h1000_0000_1FFE);

    // Both valid every cycle: alternation starting at 0 (last grant was 1)
    for (int i = 0; i < 6; i++) begin
      drive(1, 44'(100 + i), 13'(i), 1, 44'(200 + i), 13'(2 * i), 1);
      tick();
      chk("rr_id", 45'(res_id), 45'(i % 2));
      chk("rr_sum", res_sum, (i % 2) ? 45'(200 + 3 * i) : 45'(100 + 2 * i));
      chk("rr_valid", 45'(res_valid), 45'd1);
    end

    // Stall three cycles with changing operands; last grant stays 1
    held = res_sum;
    for (int i = 0; i < 3; i++) begin
      drive(1, 44'(7000 + i), 13'(i), 1, 44'(9000 + i), 13'(i), 0);
      #1;
      chk("stall_ready0", 45'(req0_ready), 45'd0);
      chk("stall_ready1", 45'(req1_ready), 45'd0);
      tick();
      chk("stall_sum", res_sum, held);
      chk("stall_id", 45'(res_id), 45'd1);
    end
    drive(1, 44'h123, 13'h10, 1, 44'h456, 13'h20, 1);
    #1;
    chk("unstall_ready0", 45'(req0_ready), 45'd1);
    tick();
    chk("unstall_id", 45'(res_id), 45'd0);
    chk("unstall_sum", res_sum, 45'h133);

    // Async reset while a result is held
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("pre_rst_valid", 45'(res_valid), 45'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 45'(res_valid), 45'd0);
    chk("async_rst_sum", res_sum, 45'd0);
    tick();
    drive(1, 44'h10, 13'h1, 1, 44'h20, 13'h2, 1);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready0", 45'(req0_ready), 45'd1);
    chk("post_rst_ready1", 45'(req1_ready), 45'd0);
    tick();
    chk("post_rst_id", 45'(res_id), 45'd0);
    chk("post_rst_sum", res_sum, 45'h11);

    // Requester 1 alone twice, then contention goes to 0
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 44'(50 + i), 13'd5, 1);
      tick();
      chk("solo1_id", 45'(res_id), 45'd1);
      chk("solo1_sum", res_sum, 45'(55 + i));
    end
    drive(1, 44'h30, 13'h3, 1, 44'h40, 13'h4, 1);
    #1;
    chk("after_solo_ready0", 45'(req0_ready), 45'd1);
    tick();
    chk("after_solo_id", 45'(res_id), 45'd0);
    chk("after_solo_sum", res_sum, 45'h33);

    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
